// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared widths, load-kind codes and writeback FSM states
package wb_stage_pkg;

  localparam int XLEN = 64;
  localparam int RA_W = 5;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LW   = 3'd1,
    LD_LD   = 3'd2,
    LD_LWU  = 3'd3,
    LD_LB   = 3'd4,
    LD_LBU  = 3'd5,
    LD_LH   = 3'd6,
    LD_LHU  = 3'd7
  } ld_kind_e;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_HALTED = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_fmt.sv
// rtl/wb_stage_load_fmt.sv - load byte-lane extraction, extension and misalign detection
module load_fmt
  import wb_stage_pkg::*;
#(
  parameter int XLEN_P = XLEN
) (
  input  logic [2:0]        i_kind,
  input  logic [2:0]        i_addr_lo,
  input  logic [XLEN_P-1:0] i_data,
  input  logic [XLEN_P-1:0] i_alu_res,
  output logic [XLEN_P-1:0] o_wdata,
  output logic              o_misalign
);

  logic [XLEN_P-1:0] w_lane;

  // Bring the addressed byte down to bit 0 of the raw doubleword.
  assign w_lane = i_data >> {i_addr_lo, 3'b000};

  // Select and extend the access width; an access is misaligned when the
  // low address bits are not a multiple of its size.
  always_comb begin
    o_wdata    = i_alu_res;
    o_misalign = 1'b0;
    case (ld_kind_e'(i_kind))
      LD_LB: o_wdata = {{(XLEN_P-8){w_lane[7]}}, w_lane[7:0]};
      LD_LBU: o_wdata = {{(XLEN_P-8){1'b0}}, w_lane[7:0]};
      LD_LH: begin
        o_wdata    = {{(XLEN_P-16){w_lane[15]}}, w_lane[15:0]};
        o_misalign = i_addr_lo[0];
      end
      LD_LHU: begin
        o_wdata    = {{(XLEN_P-16){1'b0}}, w_lane[15:0]};
        o_misalign = i_addr_lo[0];
      end
      LD_LW: begin
        o_wdata    = {{(XLEN_P-32){w_lane[31]}}, w_lane[31:0]};
        o_misalign = |i_addr_lo[1:0];
      end
      LD_LWU: begin
        o_wdata    = {{(XLEN_P-32){1'b0}}, w_lane[31:0]};
        o_misalign = |i_addr_lo[1:0];
      end
      LD_LD: begin
        o_wdata    = w_lane;
        o_misalign = |i_addr_lo;
      end
      default: o_wdata = i_alu_res;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - single-entry writeback buffer driving regfile, bypass, commit and status
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int RA_W_P = RA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN_P-1:0] in_pc,
  input  logic [RA_W_P-1:0] in_rd,
  input  logic              in_rd_wen,
  input  logic [2:0]        in_ld_kind,
  input  logic [2:0]        in_addr_lo,
  input  logic [XLEN_P-1:0] in_alu_res,
  input  logic [XLEN_P-1:0] in_ld_data,
  input  logic              in_halt,
  input  logic              wb_stall,
  output logic              rf_wen,
  output logic [RA_W_P-1:0] rf_waddr,
  output logic [XLEN_P-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [RA_W_P-1:0] fwd_rd,
  output logic [XLEN_P-1:0] fwd_data,
  output logic              commit_valid,
  output logic [XLEN_P-1:0] commit_pc,
  output logic [63:0]       instret,
  output logic              halted,
  output logic              misalign
);

  wb_state_e         r_state;
  wb_state_e         w_next;
  logic [XLEN_P-1:0] r_pc;
  logic [RA_W_P-1:0] r_rd;
  logic              r_rd_wen;
  logic [XLEN_P-1:0] r_data;
  logic              r_mis;
  logic              r_halt;
  logic [63:0]       r_instret;
  logic              r_misalign;

  logic [XLEN_P-1:0] w_fmt_data;
  logic              w_fmt_mis;
  logic              w_accept;
  logic              w_retire;
  logic              w_wr_ok;

  load_fmt #(.XLEN_P(XLEN_P)) u_load_fmt (
    .i_kind     (in_ld_kind),
    .i_addr_lo  (in_addr_lo),
    .i_data     (in_ld_data),
    .i_alu_res  (in_alu_res),
    .o_wdata    (w_fmt_data),
    .o_misalign (w_fmt_mis)
  );

  assign w_retire = (r_state == ST_FULL) && !wb_stall;
  assign w_accept = in_valid && in_ready;
  assign w_wr_ok  = r_rd_wen && (r_rd != '0) && !r_mis;

  // Next state and handshake; an ebreak retiring wins over a same-cycle accept.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        in_ready = 1'b1;
        if (w_accept) w_next = ST_FULL;
      end
      ST_FULL: begin
        in_ready = !wb_stall;
        if (w_retire) begin
          if (r_halt)         w_next = ST_HALTED;
          else if (!w_accept) w_next = ST_EMPTY;
        end
      end
      ST_HALTED: w_next = ST_HALTED;
      default:   w_next = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_next;
  end

  // Stage buffer: capture the formatted payload on every accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= '0;
      r_rd     <= '0;
      r_rd_wen <= 1'b0;
      r_data   <= '0;
      r_mis    <= 1'b0;
      r_halt   <= 1'b0;
    end else if (w_accept) begin
      r_pc     <= in_pc;
      r_rd     <= in_rd;
      r_rd_wen <= in_rd_wen;
      r_data   <= w_fmt_data;
      r_mis    <= w_fmt_mis;
      r_halt   <= in_halt;
    end
  end

  // Retired-instruction counter and sticky misalign flag, updated on retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instret  <= '0;
      r_misalign <= 1'b0;
    end else if (w_retire) begin
      r_instret <= r_instret + 64'd1;
      if (r_mis) r_misalign <= 1'b1;
    end
  end

  assign rf_wen       = w_retire && w_wr_ok;
  assign rf_waddr     = r_rd;
  assign rf_wdata     = r_data;
  assign fwd_valid    = (r_state == ST_FULL) && w_wr_ok;
  assign fwd_rd       = r_rd;
  assign fwd_data     = r_data;
  assign commit_valid = w_retire;
  assign commit_pc    = r_pc;
  assign instret      = r_instret;
  assign halted       = (r_state == ST_HALTED);
  assign misalign     = r_misalign;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - vector table plus scoreboard bench for wb_stage
module tb_wb_stage;

  typedef struct {
    logic [2:0]  kind;
    logic [2:0]  lo;
    logic [63:0] ld;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] exp_d;
    logic        exp_wen;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        mis;
    logic        halt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [2:0]  in_ld_kind;
  logic [2:0]  in_addr_lo;
  logic [63:0] in_alu_res;
  logic [63:0] in_ld_data;
  logic        in_halt;
  logic        wb_stall;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [63:0] instret;
  logic        halted;
  logic        misalign;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_commits = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [63:0] exp_ret = 0;
  logic        exp_mis = 0;
  logic        exp_halt = 0;
  vec_t        tbl[10];
  logic [63:0] next_pc = 64'h8000_0000;

  wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_ld_kind(in_ld_kind),
    .in_addr_lo(in_addr_lo), .in_alu_res(in_alu_res), .in_ld_data(in_ld_data),
    .in_halt(in_halt), .wb_stall(wb_stall), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .instret(instret),
    .halted(halted), .misalign(misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] kind, input logic [2:0] lo, input logic [63:0] ld,
                              input logic [63:0] alu, input logic [4:0] rd, input logic wen,
                              input logic [63:0] exp_d, input logic exp_wen, input logic exp_mis);
    vec_t v;
    v.kind = kind; v.lo = lo; v.ld = ld; v.alu = alu; v.rd = rd; v.wen = wen;
    v.exp_d = exp_d; v.exp_wen = exp_wen; v.exp_mis = exp_mis;
    return v;
  endfunction

  // Present one instruction starting just after a posedge; push its expectation on accept.
  task automatic send(input vec_t v, input logic halt);
    exp_t e;
    bit   ok = 0;
    in_valid = 1'b1; in_pc = next_pc; in_rd = v.rd; in_rd_wen = v.wen;
    in_ld_kind = v.kind; in_addr_lo = v.lo; in_alu_res = v.alu; in_ld_data = v.ld;
    in_halt = halt;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end else begin
      @(posedge clk);
      e.pc = next_pc; e.wen = v.exp_wen; e.waddr = v.rd; e.wdata = v.exp_d;
      e.mis = v.exp_mis; e.halt = halt;
      sb.push_back(e);
    end
    next_pc = next_pc + 64'd4;
    #1 in_valid = 1'b0;
  endtask

  task automatic check_reset();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_pc", commit_pc, 0);
    chk("rst_instret", instret, 0);
    chk("rst_halted", halted, 0);
    chk("rst_misalign", misalign, 0);
  endtask

  // Scoreboard/monitor: compares every retirement and the status model each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_ret = 0; exp_mis = 0; exp_halt = 0;
      sb.delete();
    end else begin
      chk("instret", instret, exp_ret);
      chk("misalign", misalign, {63'd0, exp_mis});
      chk("halted", halted, {63'd0, exp_halt});
      if (commit_valid) begin
        n_commits++;
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_commit: commit_pc=%h, expected no commit", commit_pc);
        end else begin
          e = sb.pop_front();
          chk("commit_pc", commit_pc, e.pc);
          chk("rf_wen", rf_wen, {63'd0, e.wen});
          chk("fwd_valid", fwd_valid, {63'd0, e.wen});
          if (e.wen) begin
            chk("rf_waddr", rf_waddr, {59'd0, e.waddr});
            chk("rf_wdata", rf_wdata, e.wdata);
            chk("fwd_rd", fwd_rd, {59'd0, e.waddr});
            chk("fwd_data", fwd_data, e.wdata);
          end
          exp_ret = exp_ret + 64'd1;
          if (e.mis) exp_mis = 1'b1;
          if (e.halt) exp_halt = 1'b1;
        end
      end else begin
        chk("rf_wen_idle", rf_wen, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int c0;
    tbl[0] = mk(3'd4, 3'd1, 64'h0000_0000_0000_8000, 64'd0, 5'd5, 1, 64'hFFFF_FFFF_FFFF_FF80, 1, 0);
    tbl[1] = mk(3'd3, 3'd4, 64'h8765_4321_0000_0000, 64'd0, 5'd6, 1, 64'h0000_0000_8765_4321, 1, 0);
    tbl[2] = mk(3'd1, 3'd4, 64'h8765_4321_0000_0000, 64'd0, 5'd7, 1, 64'hFFFF_FFFF_8765_4321, 1, 0);
    tbl[3] = mk(3'd0, 3'd0, 64'd0, 64'h1234, 5'd0, 1, 64'h1234, 0, 0);
    tbl[4] = mk(3'd2, 3'd0, 64'h0123_4567_89AB_CDEF, 64'd0, 5'd8, 1, 64'h0123_4567_89AB_CDEF, 1, 0);
    tbl[5] = mk(3'd5, 3'd7, 64'hF000_0000_0000_0000, 64'd0, 5'd9, 1, 64'h0000_0000_0000_00F0, 1, 0);
    tbl[6] = mk(3'd7, 3'd6, 64'hBEEF_0000_0000_0000, 64'd0, 5'd10, 1, 64'h0000_0000_0000_BEEF, 1, 0);
    tbl[7] = mk(3'd6, 3'd2, 64'h0000_0000_8001_0000, 64'd0, 5'd11, 1, 64'hFFFF_FFFF_FFFF_8001, 1, 0);
    tbl[8] = mk(3'd0, 3'd5, 64'h1111_2222_3333_4444, 64'hDEAD_BEEF, 5'd12, 1, 64'hDEAD_BEEF, 1, 0);
    tbl[9] = mk(3'd0, 3'd0, 64'd0, 64'h99, 5'd13, 0, 64'h99, 0, 0);

    rst = 1; in_valid = 0; in_pc = 0; in_rd = 0; in_rd_wen = 0; in_ld_kind = 0;
    in_addr_lo = 0; in_alu_res = 0; in_ld_data = 0; in_halt = 0; wb_stall = 0;
    repeat (2) @(posedge clk);
    check_reset();
    @(posedge clk); #1 rst = 0;

    // Table vectors, back to back.
    for (int i = 0; i < 10; i++) send(tbl[i], 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("sb_drain_table", sb.size(), 0);

    // Stall while FULL, then release into back-to-back traffic.
    send(mk(3'd0, 3'd0, 64'd0, 64'h55, 5'd14, 1, 64'h55, 1, 0), 1'b0);
    wb_stall = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_commit", commit_valid, 0);
      chk("stall_fwd_valid", fwd_valid, 1);
      chk("stall_fwd_data", fwd_data, 64'h55);
    end
    @(posedge clk); #1 wb_stall = 0;
    c0 = n_commits;
    start = cyc;
    for (int i = 4; i < 8; i++) send(tbl[i], 1'b0);
    chk("throughput_cycles", cyc - start, 4);
    repeat (3) @(posedge clk);
    #1 chk("stall_release_commits", n_commits - c0, 5);

    // Misaligned halfword: retires without a write, flag is sticky.
    send(mk(3'd6, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd15, 1, 64'd0, 0, 1), 1'b0);
    send(tbl[8], 1'b0);
    send(mk(3'd2, 3'd4, 64'h1, 64'd0, 5'd17, 1, 64'd0, 0, 1), 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk) chk("misalign_sticky", misalign, 1);

    // ebreak retires; stage stops accepting.
    @(posedge clk); #1;
    send(mk(3'd0, 3'd0, 64'd0, 64'h77, 5'd16, 1, 64'h77, 1, 0), 1'b1);
    @(posedge clk); #1;
    in_valid = 1; in_halt = 0; in_rd = 5'd3; in_alu_res = 64'hAA; in_ld_kind = 3'd0;
    repeat (4) begin
      @(negedge clk);
      chk("halt_in_ready", in_ready, 0);
      chk("halt_flag", halted, 1);
    end
    @(posedge clk); #1 in_valid = 0;

    // Reset from HALTED, then reset mid-FULL discards the entry.
    rst = 1;
    check_reset();
    @(posedge clk); #1 rst = 0;
    send(mk(3'd0, 3'd0, 64'd0, 64'h66, 5'd18, 1, 64'h66, 1, 0), 1'b0);
    wb_stall = 1;
    @(negedge clk) chk("pre_rst_fwd_valid", fwd_valid, 1);
    #2 rst = 1;
    #1 chk("async_rst_fwd_valid", fwd_valid, 0);
    check_reset();
    @(posedge clk); #1 rst = 0; wb_stall = 0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_commit", commit_valid, 0);
    end
    chk("post_rst_instret", instret, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the npc core, directly downstream of the memory stage. It accepts one retiring instruction per cycle over a valid/ready handshake and registers it in a single-entry stage buffer. For loads it extracts and sign/zero-extends the addressed byte lane from the raw 64-bit memory word. It then drives the register-file write port, the bypass/forwarding bus, the commit trace, the retired-instruction counter and the halt/misalign status.

## Interface
- XLEN, 64, data/address width (equals CPU_WIDTH)
- RA_W, 5, register index width
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  instruction PC
- in_rd  in  RA_W  destination register
- in_rd_wen  in  1  instruction writes rd
- in_ld_kind  in  3  0 none, 1 LW, 2 LD, 3 LWU, 4 LB, 5 LBU, 6 LH, 7 LHU
- in_addr_lo  in  3  effective address bits [2:0]
- in_alu_res  in  XLEN  non-load result
- in_ld_data  in  XLEN  raw 8-byte-aligned memory word
- in_halt  in  1  instruction is ebreak
- wb_stall  in  1  downstream (regfile port/difftest) not ready
- rf_wen  out  1  register write strobe
- rf_waddr  out  RA_W  write index
- rf_wdata  out  XLEN  write data
- fwd_valid  out  1  buffer holds a pending rd write
- fwd_rd  out  RA_W  pending rd
- fwd_data  out  XLEN  pending data
- commit_valid  out  1  instruction retires this cycle
- commit_pc  out  XLEN  retiring PC
- instret  out  64  retired count
- halted  out  1  ebreak retired
- misalign  out  1  sticky misaligned-load flag

## Operation
- States: EMPTY, FULL, HALTED. Reset -> EMPTY; all outputs 0 at reset except in_ready, which is 1.
- in_ready = (EMPTY) | (FULL & !wb_stall); 0 in HALTED.
- Accept = in_valid & in_ready. The payload is captured with the formatted result; EMPTY -> FULL.
- Retire = FULL & !wb_stall. It asserts commit_valid and commit_pc and increments instret by 1 (wraps at 2^64).
- Retire with no accept -> EMPTY. Retire plus accept -> stays FULL, holding the new payload. FULL & wb_stall -> hold everything.
- Retire of an entry with halt set -> HALTED; halted=1 until reset; no further accepts.
- Format: lane = in_ld_data >> (8*in_addr_lo).
  - LB/LBU: sign/zero-extend lane[7:0].
  - LH/LHU: sign/zero-extend lane[15:0].
  - LW/LWU: sign/zero-extend lane[31:0].
  - LD: lane.
  - kind 0: in_alu_res.
- Misaligned if addr_lo is not a multiple of the access size (H: bit0; W: bits[1:0]; D: bits[2:0]).
  - The entry still retires but its write is suppressed.
  - misalign is set on retire, sticky until reset.
- rf_wen = Retire & rd_wen_q & (rd_q != 0) & !misalign_q. rf_waddr and rf_wdata come from the buffer.
- fwd_valid = FULL & rd_wen_q & (rd_q != 0) & !misalign_q. It is independent of wb_stall.
- Reset mid-operation discards the buffered entry without retiring it; instret clears.

## Timing
- Latency: accept at edge N -> rf_wen/commit_valid high during cycle N+1 (if wb_stall=0).
- Throughput: 1 instruction/cycle with wb_stall low.
- in_ready is combinational from state and wb_stall; no combinational path from in_valid to in_ready.
- instret updates on the edge ending the retire cycle.
- halted rises on the edge ending the retire cycle of the ebreak entry.
- Outputs rf_*, fwd_*, commit_pc are driven from registers; only the strobes gate on wb_stall.

## Structure
- Add LD_NONE/LW/LD/LWU/LB/LBU/LH/LHU codes and the state encodings to rvseed_defines.
- Sub-module load_fmt: combinational lane shift, extension and misalign detection (inputs kind, addr_lo, data, alu_res; outputs wdata, misalign).
- The wb_stage top holds the FSM, buffer, counter and status flags.

## Test plan
- LB, addr_lo=1, ld_data=0x0000_0000_0000_8000, rd=5 -> cycle+1: rf_wen=1, waddr=5, wdata=0xFFFF_FFFF_FFFF_FF80, instret=1.
- LWU, addr_lo=4, ld_data=0x8765_4321_0000_0000 -> wdata=0x0000_0000_8765_4321. LW with the same inputs -> 0xFFFF_FFFF_8765_4321.
- ALU op, rd=0, alu_res=0x1234 -> commit_valid=1, rf_wen=0, fwd_valid=0, instret increments.
- Hold wb_stall=1 for 3 cycles while FULL -> in_ready=0, no commit, and fwd_data is held. Release -> one commit, then back-to-back accepts at 1/cycle.
- LH with addr_lo=3 -> no rf write, commit_valid=1, misalign=1 and it stays set.
- in_halt entry retires -> halted=1, in_ready=0 thereafter. Assert rst mid-FULL -> all outputs 0 and in_ready=1.
